// File: rtl/lap_controller.sv
// Stopwatch run-state/lap sequencer: owns the live ms count, gates the 1 ms generator, stores LAPS lap times.
// Optional LAP_SPLIT_EN: laps hold split times (delta to previous capture) instead of cumulative times.
module lap_controller #(
  parameter int TW   = 20,
  parameter int LAPS = 8,
  parameter int TMAX = 999999
) (
  input  logic                       clk,
  input  logic                       KEY2,
  input  logic                       key_start,
  input  logic                       key_lap,
  input  logic                       tick_1ms,
  output logic                       run_en,
  output logic [TW-1:0]              t_live,
  output logic [TW-1:0]              t_disp,
  output logic [$clog2(LAPS+1)-1:0]  lap_cnt,
  output logic [$clog2(LAPS)-1:0]    lap_idx,
  output logic                       lap_full,
  output logic [1:0]                 state
);

  localparam int CW = $clog2(LAPS+1);
  localparam int IW = $clog2(LAPS);
  localparam logic [TW-1:0] TMAX_V = TW'(TMAX);
  localparam logic [CW-1:0] LAPS_V = CW'(LAPS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, REVIEW = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_live_q, t_live_d;
  logic [CW-1:0]   lap_cnt_q, lap_cnt_d;
  logic [IW-1:0]   lap_idx_q, lap_idx_d;
  logic [TW-1:0]   mem_q [LAPS];
  logic [TW-1:0]   mem_d [LAPS];
  logic            lap_ev;
  logic [TW-1:0]   t_tick;
  logic [TW-1:0]   cap_val;
`ifdef LAP_SPLIT_EN
  logic [TW-1:0]   last_cap_q, last_cap_d;
`endif

  always_comb begin
    // key_start always wins a same-cycle collision
    lap_ev    = key_lap & ~key_start;
    t_tick    = (t_live_q < TMAX_V) ? t_live_q + 1'b1 : TMAX_V;
    state_d   = state_q;
    t_live_d  = t_live_q;
    lap_cnt_d = lap_cnt_q;
    lap_idx_d = lap_idx_q;
    mem_d     = mem_q;
    cap_val   = '0;
`ifdef LAP_SPLIT_EN
    last_cap_d = last_cap_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_start) state_d = RUN;
      end
      RUN: begin
        if (tick_1ms) begin
          t_live_d = t_tick;
          if (t_tick == TMAX_V) state_d = HOLD;
        end
        if (key_start) begin
          state_d = HOLD;
        end else if (lap_ev && (lap_cnt_q < LAPS_V)) begin
          // capture uses the post-edge time so a coincident tick is included
`ifdef LAP_SPLIT_EN
          cap_val    = t_live_d - last_cap_q;
          last_cap_d = t_live_d;
`else
          cap_val    = t_live_d;
`endif
          mem_d[IW'(lap_cnt_q)] = cap_val;
          lap_cnt_d = lap_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (key_start) begin
          state_d = RUN;
        end else if (lap_ev) begin
          if (lap_cnt_q != '0) begin
            state_d   = REVIEW;
            lap_idx_d = '0;
          end else begin
            state_d  = IDLE;
            t_live_d = '0;
`ifdef LAP_SPLIT_EN
            last_cap_d = '0;
`endif
          end
        end
      end
      REVIEW: begin
        if (key_start) begin
          state_d   = IDLE;
          t_live_d  = '0;
          lap_cnt_d = '0;
          lap_idx_d = '0;
`ifdef LAP_SPLIT_EN
          last_cap_d = '0;
`endif
        end else if (lap_ev) begin
          if ((CW'(lap_idx_q) + 1'b1) < lap_cnt_q) begin
            lap_idx_d = lap_idx_q + 1'b1;
          end else begin
            state_d   = HOLD;
            lap_idx_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) begin
      state_q   <= IDLE;
      t_live_q  <= '0;
      lap_cnt_q <= '0;
      lap_idx_q <= '0;
      for (int i = 0; i < LAPS; i++) mem_q[i] <= '0;
`ifdef LAP_SPLIT_EN
      last_cap_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      t_live_q  <= t_live_d;
      lap_cnt_q <= lap_cnt_d;
      lap_idx_q <= lap_idx_d;
      mem_q     <= mem_d;
`ifdef LAP_SPLIT_EN
      last_cap_q <= last_cap_d;
`endif
    end
  end

  assign run_en   = (state_q == RUN);
  assign t_live   = t_live_q;
  assign t_disp   = (state_q == REVIEW) ? mem_q[lap_idx_q] : t_live_q;
  assign lap_cnt  = lap_cnt_q;
  assign lap_idx  = lap_idx_q;
  assign lap_full = (lap_cnt_q == LAPS_V);
  assign state    = state_q;

endmodule

// File: tb/tb_lap_controller.sv
// Bench for lap_controller: directed table, corner sequences and random stimulus against a lap-list model.
module tb_lap_controller;

`ifdef LAP_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic KEY2, key_start, key_lap, tick_1ms;

  logic        run_en0, lap_full0, run_en1, lap_full1;
  logic [19:0] t_live0, t_disp0, t_live1, t_disp1;
  logic [3:0]  lap_cnt0, lap_cnt1;
  logic [2:0]  lap_idx0, lap_idx1;
  logic [1:0]  state0, state1;

  lap_controller #(.TW(20), .LAPS(8), .TMAX(999999)) dut (
    .clk(clk), .KEY2(KEY2), .key_start(key_start), .key_lap(key_lap), .tick_1ms(tick_1ms),
    .run_en(run_en0), .t_live(t_live0), .t_disp(t_disp0), .lap_cnt(lap_cnt0),
    .lap_idx(lap_idx0), .lap_full(lap_full0), .state(state0));

  lap_controller #(.TW(20), .LAPS(8), .TMAX(50)) dut_s (
    .clk(clk), .KEY2(KEY2), .key_start(key_start), .key_lap(key_lap), .tick_1ms(tick_1ms),
    .run_en(run_en1), .t_live(t_live1), .t_disp(t_disp1), .lap_cnt(lap_cnt1),
    .lap_idx(lap_idx1), .lap_full(lap_full1), .state(state1));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: states 0..3 = IDLE/RUN/HOLD/REVIEW, laps kept as a plain list.
  int m_st[2], m_t[2], m_n[2], m_idx[2], m_last[2];
  int m_laps[2][8];
  int m_tmax[2] = '{999999, 50};

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_t[k] = 0; m_n[k] = 0; m_idx[k] = 0; m_last[k] = 0;
      for (int j = 0; j < 8; j++) m_laps[k][j] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit l, input bit tk);
    for (int k = 0; k < 2; k++) begin
      int nst;
      nst = m_st[k];
      case (m_st[k])
        0: if (s) nst = 1;
        1: begin
          if (tk) begin
            if (m_t[k] < m_tmax[k]) m_t[k]++;
            if (m_t[k] == m_tmax[k]) nst = 2;
          end
          if (s) nst = 2;
          else if (l && m_n[k] < 8) begin
            m_laps[k][m_n[k]] = SPLIT ? m_t[k] - m_last[k] : m_t[k];
            m_last[k] = m_t[k];
            m_n[k]++;
          end
        end
        2: if (s) nst = 1;
           else if (l) begin
             if (m_n[k] > 0) begin nst = 3; m_idx[k] = 0; end
             else begin nst = 0; m_t[k] = 0; m_last[k] = 0; end
           end
        3: if (s) begin
             nst = 0; m_t[k] = 0; m_n[k] = 0; m_idx[k] = 0; m_last[k] = 0;
           end else if (l) begin
             if (m_idx[k] < m_n[k] - 1) m_idx[k]++;
             else begin nst = 2; m_idx[k] = 0; end
           end
        default: ;
      endcase
      m_st[k] = nst;
    end
  endtask

  function automatic int m_disp(input int k);
    return (m_st[k] == 3) ? m_laps[k][m_idx[k]] : m_t[k];
  endfunction

  task automatic check_model();
    cmp("m0.state",   state0,    m_st[0]);
    cmp("m0.run_en",  run_en0,   int'(m_st[0] == 1));
    cmp("m0.t_live",  t_live0,   m_t[0]);
    cmp("m0.t_disp",  t_disp0,   m_disp(0));
    cmp("m0.lap_cnt", lap_cnt0,  m_n[0]);
    cmp("m0.lap_idx", lap_idx0,  m_idx[0]);
    cmp("m0.full",    lap_full0, int'(m_n[0] == 8));
    cmp("m1.state",   state1,    m_st[1]);
    cmp("m1.t_live",  t_live1,   m_t[1]);
    cmp("m1.t_disp",  t_disp1,   m_disp(1));
    cmp("m1.lap_cnt", lap_cnt1,  m_n[1]);
    cmp("m1.lap_idx", lap_idx1,  m_idx[1]);
  endtask

  task automatic cycle(input bit s, input bit l, input bit tk);
    key_start = s; key_lap = l; tick_1ms = tk;
    @(posedge clk);
    model_step(s, l, tk);
    #1;
    key_start = 1'b0; key_lap = 1'b0; tick_1ms = 1'b0;
    check_model();
  endtask

  task automatic ticks(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    KEY2 = 1'b0;
    model_reset();
    #3;
    KEY2 = 1'b1;
  endtask

  typedef struct {
    bit s; bit l; int nt; int est; int edisp; int ecnt;
  } vec_t;
  vec_t tbl[19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 0,    1, 0,    0};
    tbl[1]  = '{1'b0, 1'b1, 100,  1, 100,  1};
    tbl[2]  = '{1'b0, 1'b1, 150,  1, 250,  2};
    tbl[3]  = '{1'b0, 1'b1, 150,  1, 400,  3};
    tbl[4]  = '{1'b1, 1'b0, 100,  2, 500,  3};
    tbl[5]  = '{1'b0, 1'b1, 0,    3, 100,  3};
    tbl[6]  = '{1'b0, 1'b1, 0,    3, SPLIT ? 150 : 250, 3};
    tbl[7]  = '{1'b0, 1'b1, 0,    3, SPLIT ? 150 : 400, 3};
    tbl[8]  = '{1'b0, 1'b1, 0,    2, 500,  3};
    tbl[9]  = '{1'b0, 1'b0, 10,   2, 500,  3};
    tbl[10] = '{1'b1, 1'b0, 0,    1, 500,  3};
    tbl[11] = '{1'b1, 1'b1, 0,    2, 500,  3};
    tbl[12] = '{1'b0, 1'b1, 0,    3, 100,  3};
    tbl[13] = '{1'b1, 1'b0, 0,    0, 0,    0};
    tbl[14] = '{1'b0, 1'b1, 0,    0, 0,    0};
    tbl[15] = '{1'b1, 1'b0, 0,    1, 0,    0};
    tbl[16] = '{1'b1, 1'b0, 1500, 2, 1500, 0};
    tbl[17] = '{1'b0, 1'b0, 10,   2, 1500, 0};
    tbl[18] = '{1'b0, 1'b1, 0,    0, 0,    0};

    key_start = 1'b0; key_lap = 1'b0; tick_1ms = 1'b0;
    KEY2 = 1'b0;
    model_reset();
    #2;
    cmp("rst.state",   state0,    0);
    cmp("rst.t_live",  t_live0,   0);
    cmp("rst.t_disp",  t_disp0,   0);
    cmp("rst.lap_cnt", lap_cnt0,  0);
    cmp("rst.run_en",  run_en0,   0);
    cmp("rst.full",    lap_full0, 0);
    #1;
    KEY2 = 1'b1;

    for (int i = 0; i < 19; i++) begin
      ticks(tbl[i].nt);
      if (tbl[i].s || tbl[i].l) cycle(tbl[i].s, tbl[i].l, 1'b0);
      cmp($sformatf("tbl%0d.state", i),   state0,    tbl[i].est);
      cmp($sformatf("tbl%0d.t_disp", i),  t_disp0,   tbl[i].edisp);
      cmp($sformatf("tbl%0d.lap_cnt", i), lap_cnt0,  tbl[i].ecnt);
      cmp($sformatf("tbl%0d.run_en", i),  run_en0,   int'(tbl[i].est == 1));
    end

    // Nine laps into an eight-deep buffer
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      ticks(3);
      cycle(1'b0, 1'b1, 1'b0);
    end
    cmp("full.lap_cnt", lap_cnt0, 8);
    cmp("full.flag",    lap_full0, 1);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    cmp("full.idx7",  lap_idx0, 7);
    cmp("full.lap8",  t_disp0, SPLIT ? 3 : 24);
    cycle(1'b0, 1'b1, 1'b0);
    cmp("full.back_hold", state0, 2);
    cmp("full.back_disp", t_disp0, 27);

    // Saturation at TMAX=50
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    ticks(49);
    cmp("sat.state49", state1, 1);
    cmp("sat.t49",     t_live1, 49);
    ticks(1);
    cmp("sat.state50", state1, 2);
    cmp("sat.t50",     t_live1, 50);
    cmp("sat.run_en",  run_en1, 0);
    ticks(10);
    cmp("sat.t60",     t_live1, 50);

    // Tick coincident with lap, then with stop
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    ticks(99);
    cycle(1'b0, 1'b1, 1'b1);
    cmp("co_lap.cnt", lap_cnt0, 1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cmp("co_lap.disp", t_disp0, 100);
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    ticks(99);
    cycle(1'b1, 1'b0, 1'b1);
    cmp("co_stop.state", state0, 2);
    cmp("co_stop.t",     t_live0, 100);

    // Asynchronous reset mid-run
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ticks(100);
      cycle(1'b0, 1'b1, 1'b0);
    end
    ticks(400);
    cmp("arst.pre_t",   t_live0, 700);
    cmp("arst.pre_cnt", lap_cnt0, 3);
    #2;
    KEY2 = 1'b0;
    #1;
    cmp("arst.state",  state0, 0);
    cmp("arst.t_live", t_live0, 0);
    cmp("arst.t_disp", t_disp0, 0);
    cmp("arst.cnt",    lap_cnt0, 0);
    cmp("arst.idx",    lap_idx0, 0);
    cmp("arst.full",   lap_full0, 0);
    cmp("arst.run_en", run_en0, 0);
    model_reset();
    #3;
    KEY2 = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    ticks(5);
    cmp("arst.restart_t", t_live0, 5);
    cmp("arst.restart_cnt", lap_cnt0, 0);

    // Random stimulus against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 999) do_reset();
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lap_controller.md
Name: lap_controller

Overview:
- Run-state and lap sequencer for the stopwatch datapath.
- Consumes debounced single-cycle key pulses and the 1 ms strobe, and owns the running millisecond count.
- Gates the 1 ms generator and records up to LAPS lap times in an internal register file.
- Drives the value fed to the digit transformer and 7-segment display, either the live time or a reviewed lap.

Parameters:
- TW, 20: width of every time value, in ms.
- LAPS, 8: lap buffer depth; must be ≥2.
- TMAX, 999999: saturation ceiling for the live time (6 display digits).

Ports:
- clk  in  1  system clock.
- KEY2  in  1  asynchronous active-low reset.
- key_start  in  1  debounced one-cycle start/stop pulse, synchronous to clk.
- key_lap  in  1  debounced one-cycle lap/review pulse, synchronous to clk.
- tick_1ms  in  1  one-cycle strobe per millisecond.
- run_en  out  1  enable to the 1 ms generator; equals (state==RUN).
- t_live  out  TW  accumulated time.
- t_disp  out  TW  value to display.
- lap_cnt  out  $clog2(LAPS+1)  number of stored laps.
- lap_idx  out  $clog2(LAPS)  lap currently reviewed.
- lap_full  out  1  high when lap_cnt==LAPS.
- state  out  2  IDLE=0, RUN=1, HOLD=2, REVIEW=3.

Behaviour:
- Reset (KEY2=0, asynchronous, no clock edge needed):
  - state=IDLE; t_live=0, lap_cnt=0, lap_idx=0; lap memory cleared.
  - All outputs read 0.
- IDLE:
  - key_start → RUN.
  - key_lap ignored.
- RUN, tick_1ms:
  - t_live increments by 1 on the edge.
  - At t_live==TMAX a tick does not wrap: t_live stays TMAX and state → HOLD on that edge.
- RUN, key_start: → HOLD.
- RUN, key_lap:
  - If lap_cnt<LAPS: mem[lap_cnt] gets the capture value and lap_cnt increments.
  - If full: the pulse is dropped and nothing changes.
  - Capture value is the t_live value valid after the same edge, so a coincident tick is included.
- HOLD:
  - key_start → RUN (resume, t_live kept).
  - key_lap with lap_cnt>0 → REVIEW, lap_idx=0.
  - key_lap with lap_cnt==0 → IDLE, t_live=0.
- REVIEW:
  - key_lap with lap_idx<lap_cnt-1: lap_idx increments.
  - key_lap with lap_idx==lap_cnt-1: → HOLD, lap_idx=0.
  - key_start → IDLE; clears t_live, lap_cnt and lap_idx.
- Simultaneous events:
  - key_start and key_lap in the same cycle: key_start wins and key_lap is discarded, in every state.
  - tick_1ms with key_start in RUN: the tick is counted, then HOLD.
  - Ticks outside RUN are ignored.
- t_disp:
  - Combinational mux of registered state, no added latency.
  - REVIEW: mem[lap_idx]. All other states: t_live.
- lap_full:
  - Combinational from lap_cnt.
  - Stays high until a clear through IDLE or reset.
- Arithmetic is unsigned TW-bit with no wrap anywhere.

Optional Feature:
- Macro LAP_SPLIT_EN.
- Defined: each lap stores a split, i.e. capture value minus the previous capture (minus 0 for the first lap). A hidden TW-bit last_capture register is added; it is cleared wherever t_live is cleared.
- Undefined: laps store the cumulative capture value and there is no extra register.

Test Plan:
- Reset, then key_start, 1500 ticks, key_start → t_disp=1500, state=HOLD, run_en=0; 10 further ticks leave 1500.
- RUN with key_lap after ticks 100, 250 and 400, stop at 500, then four key_lap pulses:
  - Without LAP_SPLIT_EN: displays 100, 250, 400, then 500 with state=HOLD.
  - With LAP_SPLIT_EN: displays 100, 150, 150, then 500.
- Nine key_lap pulses in RUN (LAPS=8) → lap_cnt=8, lap_full=1; mem[7] holds the 8th capture and the 9th is dropped.
- TMAX=50 override, 60 ticks in RUN → t_live=50, state=HOLD on the 50th tick.
- Coincidence checks in RUN:
  - key_start+key_lap together → HOLD, lap_cnt unchanged.
  - tick+key_lap at t_live=99 → stored lap 100.
  - tick+key_start at t_live=99 → HOLD with t_live=100.
- KEY2 low between clock edges during RUN at t_live=700 with 3 laps → all outputs 0 and state=IDLE before the next edge; after release, key_start restarts from 0.
